// File: rtl/counter_ctrl.sv
// Sequencing controller for an external loadable up/down counter: accepts a
// start/end/direction command, loads the counter, counts to the end value.
module counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic             cmd_dir,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero,
    output logic             load_n,
    output logic [WIDTH-1:0] data_load,
    output logic             up_down,
    output logic             ce,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] steps,
    output logic             wrapped
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] start_r, end_r;
    logic             dir_r;
    logic             accept;

    assign accept    = cmd_valid && cmd_ready;
    assign data_load = start_r;
    assign up_down   = dir_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r <= '0;
            end_r   <= '0;
            dir_r   <= 1'b0;
            steps   <= '0;
            wrapped <= 1'b0;
        end else if (accept) begin
            start_r <= cmd_start;
            end_r   <= cmd_end;
            dir_r   <= cmd_dir;
            steps   <= '0;
            wrapped <= 1'b0;
        end else begin
            if (ce) steps <= steps + WIDTH'(1);
            // The counter's flag reflects its value before this count, so a
            // count taken on all-ones (up) or zero (down) is the wrap step.
            if (ce && ((dir_r && max_count) || (!dir_r && zero))) wrapped <= 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        load_n    = 1'b1;
        ce        = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nx = LOAD;
            end
            LOAD: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    load_n   = 1'b0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                // Abort wins over completion; pause freezes the state even on the end value.
                if (abort)                   state_nx = IDLE;
                else if (pause)              state_nx = RUN;
                else if (count_out == end_r) state_nx = DONE;
                else                         ce       = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter data width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accept; a command is taken when cmd_valid && cmd_ready at a rising edge.
REQ-006 SHALL have port cmd_start  input  WIDTH  value to load into the counter.
REQ-007 SHALL have port cmd_end  input  WIDTH  terminal value.
REQ-008 SHALL have port cmd_dir  input  1  1 = count up, 0 = count down.
REQ-009 SHALL have port pause  input  1  suspends counting while high.
REQ-010 SHALL have port abort  input  1  cancels the active sequence.
REQ-011 SHALL have port count_out  input  WIDTH  counter value fed back from the counter.
REQ-012 SHALL have port max_count  input  1  counter all-ones flag fed back from the counter.
REQ-013 SHALL have port zero  input  1  counter zero flag fed back from the counter.
REQ-014 SHALL have port load_n  output  1  active-low synchronous load request to the counter.
REQ-015 SHALL have port data_load  output  WIDTH  value to load into the counter.
REQ-016 SHALL have port up_down  output  1  count direction to the counter.
REQ-017 SHALL have port ce  output  1  count enable to the counter.
REQ-018 SHALL have port busy  output  1  high while a sequence is in progress.
REQ-019 SHALL have port done  output  1  one-cycle pulse marking normal completion.
REQ-020 SHALL have port steps  output  WIDTH  number of ce cycles issued in the current or last sequence.
REQ-021 SHALL have port wrapped  output  1  set when the counter crossed all-ones to 0 (up) or 0 to all-ones (down).

Function
REQ-022 SHALL implement a four-state FSM: IDLE, LOAD, RUN, DONE.
REQ-023 IDLE SHALL drive cmd_ready=1, busy=0, load_n=1, ce=0; every other state SHALL drive cmd_ready=0, busy=1.
REQ-024 On an accepted command the block SHALL register cmd_start, cmd_end and cmd_dir, clear steps and wrapped, and move to LOAD.
REQ-025 LOAD SHALL last exactly one cycle, driving load_n=0, data_load=the registered start value and ce=0, then move to RUN.
REQ-026 In RUN, up_down SHALL equal the registered direction, and ce SHALL be combinational: ce = !pause && !abort && (count_out != end).
REQ-027 In RUN with count_out == end, the block SHALL move to DONE with ce=0; no extra count may be issued.
REQ-028 steps SHALL increment by 1 on every rising edge at which ce=1, wrapping modulo 2^WIDTH.
REQ-029 wrapped SHALL be set at an edge where ce=1 and either up_down=1 with max_count=1, or up_down=0 with zero=1; once set it SHALL hold until the next accepted command.
REQ-030 DONE SHALL last exactly one cycle, drive done=1, then return to IDLE.
REQ-031 steps and wrapped SHALL hold their values in IDLE until the next accepted command.
REQ-032 When start == end, the block SHALL go LOAD -> RUN -> DONE with steps=0 and wrapped=0.
REQ-033 While pause is high in RUN, ce SHALL be 0 and state and steps SHALL hold.
REQ-034 abort in LOAD or RUN SHALL force ce=0 and load_n=1 in that cycle and move the FSM to IDLE at the next edge without pulsing done.
REQ-035 abort SHALL have no effect in IDLE or DONE.
REQ-036 cmd_valid outside IDLE SHALL be ignored, with no command queued.
REQ-037 When load_n=1, data_load SHALL hold the registered start value.

Reset
REQ-038 When rst_n=0, at any time including mid-sequence, the block SHALL asynchronously enter IDLE.
REQ-039 In reset, outputs SHALL be: cmd_ready=1, busy=0, done=0, load_n=1, ce=0, up_down=0, data_load=0, steps=0, wrapped=0.
REQ-040 Normal operation SHALL resume at the first rising edge after rst_n deasserts.

Verification (WIDTH=4, paired with the counter)
REQ-041 Command start=3, end=7, up -> one LOAD cycle with data_load=3, then 4 ce cycles, then done pulse; count_out=7, steps=4, wrapped=0.
REQ-042 Command start=2, end=14, down -> counter sequence 2,1,0,15,14; steps=4, wrapped=1, done pulse.
REQ-043 Command start=9, end=9 -> steps=0, no ce asserted, done pulse 2 cycles after LOAD.
REQ-044 pause held 3 cycles mid-run of start=0, end=5, up -> ce=0 for those 3 cycles, count_out held; final steps=5.
REQ-045 abort in the 2nd RUN cycle of start=0, end=10 -> ce=0 that cycle, IDLE next cycle, no done, steps=1; a new cmd_valid is accepted the following cycle.
REQ-046 rst_n low mid-run -> IDLE immediately with all outputs at reset values; cmd_valid held during busy is never accepted.
